// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem memory-port arbiter.
// Build option: MEM_PORT_ARBITER_DMEM_PRIO_EN selects fixed dmem priority.
package mem_port_arbiter_pkg;

    typedef enum logic {
        SRC_IMEM = 1'b0,
        SRC_DMEM = 1'b1
    } src_t;

    localparam int CORE_ADDR_W = 32;
    localparam int CORE_DATA_W = 32;
    localparam int CORE_BE_W   = CORE_DATA_W / 8;

    typedef struct packed {
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
        logic [CORE_BE_W-1:0]   byte_en;
    } mem_req_t;

    // A single-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response channel between a requester (master) and a memory (slave).
// Used for the imem, dmem and external memory sides of the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_byte_en;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;

    modport master (
        output req_valid, req_addr, req_wdata, req_byte_en, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_byte_en, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order FIFO of request source ids; the head names the owner of the next response.
module mem_port_arbiter_tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic push,
    input  src_t push_src,
    input  logic pop,
    output logic full,
    output logic empty,
    output src_t head
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    src_t             entry_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Explicit wrap keeps non-power-of-two pointer ranges (DEPTH=1) in bounds.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= SRC_IMEM;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                entry_reg[wr_ptr_reg] <= push_src;
                wr_ptr_reg            <= next_ptr(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between imem and dmem; responses are routed back in issue order.
// Build option: MEM_PORT_ARBITER_DMEM_PRIO_EN gives dmem fixed priority instead of round-robin.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    mem_port_arbiter_if.slave    imem,
    mem_port_arbiter_if.slave    dmem,
    mem_port_arbiter_if.master   mem
);
    localparam int BE_W = DATA_W / 8;

    src_t              gnt_src;
    logic              gnt_valid;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic [BE_W-1:0]   gnt_byte_en;
    logic              lock_valid_reg;
    src_t              lock_owner_reg;
    logic              m_req_valid;
    logic              req_fire;
    logic              rsp_fire;
    logic              head_rsp_ready;
    logic              fifo_full;
    logic              fifo_empty;
    src_t              fifo_head;

`ifndef MEM_PORT_ARBITER_DMEM_PRIO_EN
    src_t              last_grant_reg;
`endif

    always_comb begin
        gnt_src   = SRC_IMEM;
        gnt_valid = 1'b0;
        if (lock_valid_reg) begin
            gnt_src   = lock_owner_reg;
            gnt_valid = (lock_owner_reg == SRC_DMEM) ? dmem.req_valid : imem.req_valid;
        end else if (imem.req_valid && dmem.req_valid) begin
`ifdef MEM_PORT_ARBITER_DMEM_PRIO_EN
            gnt_src   = SRC_DMEM;
`else
            gnt_src   = (last_grant_reg == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
`endif
            gnt_valid = 1'b1;
        end else if (dmem.req_valid) begin
            gnt_src   = SRC_DMEM;
            gnt_valid = 1'b1;
        end else if (imem.req_valid) begin
            gnt_src   = SRC_IMEM;
            gnt_valid = 1'b1;
        end
    end

    assign gnt_addr    = (gnt_src == SRC_DMEM) ? dmem.req_addr    : imem.req_addr;
    assign gnt_wdata   = (gnt_src == SRC_DMEM) ? dmem.req_wdata   : imem.req_wdata;
    assign gnt_byte_en = (gnt_src == SRC_DMEM) ? dmem.req_byte_en : imem.req_byte_en;

    // Fullness is registered state only, so a same-cycle pop never frees a slot.
    assign m_req_valid     = gnt_valid && !fifo_full;
    assign req_fire        = m_req_valid && mem.req_ready;
    assign mem.req_valid   = m_req_valid;
    assign mem.req_addr    = m_req_valid ? gnt_addr    : '0;
    assign mem.req_wdata   = m_req_valid ? gnt_wdata   : '0;
    assign mem.req_byte_en = m_req_valid ? gnt_byte_en : '0;
    assign imem.req_ready  = req_fire && (gnt_src == SRC_IMEM);
    assign dmem.req_ready  = req_fire && (gnt_src == SRC_DMEM);

    assign head_rsp_ready = (fifo_head == SRC_DMEM) ? dmem.rsp_ready : imem.rsp_ready;
    assign mem.rsp_ready  = !fifo_empty && head_rsp_ready;
    assign rsp_fire       = mem.rsp_valid && mem.rsp_ready;
    assign imem.rsp_valid = mem.rsp_valid && !fifo_empty && (fifo_head == SRC_IMEM);
    assign dmem.rsp_valid = mem.rsp_valid && !fifo_empty && (fifo_head == SRC_DMEM);
    assign imem.rsp_data  = mem.rsp_data;
    assign dmem.rsp_data  = mem.rsp_data;

    // A stalled offer pins the owner so the m_req_* fields cannot switch source.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_valid_reg <= 1'b0;
            lock_owner_reg <= SRC_IMEM;
        end else if (req_fire) begin
            lock_valid_reg <= 1'b0;
        end else if (m_req_valid) begin
            lock_valid_reg <= 1'b1;
            lock_owner_reg <= gnt_src;
        end
    end

`ifndef MEM_PORT_ARBITER_DMEM_PRIO_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant_reg <= SRC_IMEM;
        end else if (req_fire) begin
            last_grant_reg <= gnt_src;
        end
    end
`endif

    mem_port_arbiter_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (req_fire),
        .push_src (gnt_src),
        .pop      (rsp_fire),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based reference model.
// Honours MEM_PORT_ARBITER_DMEM_PRIO_EN for the expected grant order.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic CLK;
    logic RST_N;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) imem_if ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dmem_if ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .imem  (imem_if),
        .dmem  (dmem_if),
        .mem   (mem_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: outstanding sources in issue order (0 = imem, 1 = dmem).
    bit q[$];
    bit last_g, lock_v, lock_o, owner;
    bit e_mvalid, e_iready, e_dready, e_mrsp_ready, e_irsp_valid, e_drsp_valid;
    bit fired_i, fired_d, fired_rsp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lock_v = 1'b0;
        lock_o = 1'b0;
        last_g = 1'b0;
    endtask

    task automatic model_eval();
        bit iv, dv, ov, full;
        iv   = imem_if.req_valid;
        dv   = dmem_if.req_valid;
        full = (q.size() >= DEPTH);
        if (lock_v)         owner = lock_o;
        else if (iv && dv) begin
`ifdef MEM_PORT_ARBITER_DMEM_PRIO_EN
            owner = 1'b1;
`else
            owner = !last_g;
`endif
        end
        else                owner = dv;
        ov           = owner ? dv : iv;
        e_mvalid     = ov && !full;
        e_iready     = e_mvalid && !owner && mem_if.req_ready;
        e_dready     = e_mvalid &&  owner && mem_if.req_ready;
        e_mrsp_ready = (q.size() > 0) && (q[0] ? dmem_if.rsp_ready : imem_if.rsp_ready);
        e_irsp_valid = mem_if.rsp_valid && (q.size() > 0) && !q[0];
        e_drsp_valid = mem_if.rsp_valid && (q.size() > 0) &&  q[0];
    endtask

    task automatic check_all();
        chk("m_req_valid", mem_if.req_valid, e_mvalid);
        chk("i_req_ready", imem_if.req_ready, e_iready);
        chk("d_req_ready", dmem_if.req_ready, e_dready);
        chk("m_rsp_ready", mem_if.rsp_ready, e_mrsp_ready);
        chk("i_rsp_valid", imem_if.rsp_valid, e_irsp_valid);
        chk("d_rsp_valid", dmem_if.rsp_valid, e_drsp_valid);
        chk("i_rsp_data", imem_if.rsp_data, mem_if.rsp_data);
        chk("d_rsp_data", dmem_if.rsp_data, mem_if.rsp_data);
        if (e_mvalid) begin
            chk("m_req_addr", mem_if.req_addr, owner ? dmem_if.req_addr : imem_if.req_addr);
            chk("m_req_wdata", mem_if.req_wdata, owner ? dmem_if.req_wdata : imem_if.req_wdata);
            chk("m_req_be", mem_if.req_byte_en, owner ? dmem_if.req_byte_en : imem_if.req_byte_en);
        end else if (!imem_if.req_valid && !dmem_if.req_valid) begin
            chk("idle_addr", mem_if.req_addr, 0);
            chk("idle_be", mem_if.req_byte_en, 0);
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        check_all();
    endtask

    task automatic advance();
        @(posedge CLK);
        fired_i   = e_iready;
        fired_d   = e_dready;
        fired_rsp = mem_if.rsp_valid && e_mrsp_ready;
        if (fired_rsp) void'(q.pop_front());
        if (e_mvalid && mem_if.req_ready) begin
            q.push_back(owner);
            last_g = owner;
            lock_v = 1'b0;
        end else if (e_mvalid) begin
            lock_v = 1'b1;
            lock_o = owner;
        end
        @(negedge CLK);
    endtask

    task automatic set_req(input bit d, input bit v, input logic [31:0] a,
                           input logic [31:0] w, input logic [3:0] be);
        if (d) begin
            dmem_if.req_valid = v; dmem_if.req_addr = a;
            dmem_if.req_wdata = w; dmem_if.req_byte_en = be;
        end else begin
            imem_if.req_valid = v; imem_if.req_addr = a;
            imem_if.req_wdata = w; imem_if.req_byte_en = be;
        end
    endtask

    task automatic idle_all();
        set_req(1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0);
        imem_if.rsp_ready = 1'b0;
        dmem_if.rsp_ready = 1'b0;
        mem_if.req_ready  = 1'b0;
        mem_if.rsp_valid  = 1'b0;
        mem_if.rsp_data   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seq [4];
        mem_req_t i_cur, d_cur;
        bit i_pend, d_pend, rsp_hold;
        logic [31:0] rsp_val;

        RST_N = 1'b0;
        idle_all();
        model_reset();
        @(negedge CLK);
        settle();
        @(negedge CLK);
        RST_N = 1'b1;
        settle();
        advance();

        // Single imem read with response one cycle later.
        set_req(1'b0, 1'b1, 32'h40, '0, 4'h0);
        mem_if.req_ready = 1'b1;
        settle();
        chk("t1_i_req_ready", imem_if.req_ready, 1);
        advance();
        set_req(1'b0, 1'b0, '0, '0, '0);
        imem_if.rsp_ready = 1'b1;
        dmem_if.rsp_ready = 1'b1;
        mem_if.rsp_valid  = 1'b1;
        mem_if.rsp_data   = 32'hDEADBEEF;
        settle();
        chk("t1_i_rsp_valid", imem_if.rsp_valid, 1);
        chk("t1_i_rsp_data", imem_if.rsp_data, 32'hDEADBEEF);
        chk("t1_d_rsp_valid", dmem_if.rsp_valid, 0);
        advance();
        mem_if.rsp_valid = 1'b0;

        // Both requesters continuously valid: d, i, d, i (or all d with fixed priority).
`ifdef MEM_PORT_ARBITER_DMEM_PRIO_EN
        seq = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
`else
        seq = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
`endif
        set_req(1'b0, 1'b1, 32'h1000, 32'h11, 4'h0);
        set_req(1'b1, 1'b1, 32'h2000, 32'h22, 4'hF);
        for (int k = 0; k < 4; k++) begin
            mem_if.rsp_valid = (q.size() != 0);
            mem_if.rsp_data  = 32'(k);
            settle();
            chk("rr_grant_addr", mem_if.req_addr, seq[k]);
            if (k > 0) chk("rr_route_d", dmem_if.rsp_valid, seq[k-1] == 32'h2000);
            advance();
        end
        set_req(1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0);
        mem_if.rsp_valid = 1'b1;
        settle();
        chk("rr_route_last_d", dmem_if.rsp_valid, seq[3] == 32'h2000);
        advance();
        mem_if.rsp_valid = 1'b0;

        // Lock: stalled dmem write keeps m_req_* stable while imem waits.
        set_req(1'b1, 1'b1, 32'h100, 32'hCAFE, 4'h3);
        set_req(1'b0, 1'b1, 32'h200, 32'h0, 4'h0);
        mem_if.req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("lock_addr", mem_if.req_addr, 32'h100);
            chk("lock_be", mem_if.req_byte_en, 4'h3);
            chk("lock_i_ready", imem_if.req_ready, 0);
            advance();
        end
        mem_if.req_ready = 1'b1;
        settle();
        chk("lock_d_accept", dmem_if.req_ready, 1);
        advance();
        set_req(1'b1, 1'b0, '0, '0, '0);
        settle();
        chk("lock_i_after", mem_if.req_addr, 32'h200);
        chk("lock_i_ready", imem_if.req_ready, 1);
        advance();

        // Full FIFO: no request until a registered slot frees up.
        set_req(1'b0, 1'b1, 32'h300, 32'h0, 4'h0);
        settle();
        chk("full_m_req_valid", mem_if.req_valid, 0);
        chk("full_i_ready", imem_if.req_ready, 0);
        advance();
        mem_if.rsp_valid = 1'b1;
        settle();
        chk("full_pop_same_cycle", mem_if.req_valid, 0);
        chk("full_pop_route_d", dmem_if.rsp_valid, 1);
        advance();
        mem_if.rsp_valid = 1'b0;
        settle();
        chk("full_next_cycle", mem_if.req_valid, 1);
        advance();
        set_req(1'b0, 1'b0, '0, '0, '0);

        // Response backpressure from imem.
        imem_if.rsp_ready = 1'b0;
        mem_if.rsp_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("bp_m_rsp_ready", mem_if.rsp_ready, 0);
            chk("bp_i_rsp_valid", imem_if.rsp_valid, 1);
            advance();
        end
        imem_if.rsp_ready = 1'b1;
        settle();
        chk("bp_release", mem_if.rsp_ready, 1);
        advance();
        mem_if.rsp_valid = 1'b0;

        // Reset mid-transaction with one outstanding and a locked request.
        set_req(1'b1, 1'b1, 32'h500, 32'h5, 4'h1);
        mem_if.req_ready = 1'b0;
        settle();
        advance();
        settle();
        idle_all();
        RST_N = 1'b0;
        #1;
        model_reset();
        model_eval();
        check_all();
        chk("rst_m_req_valid", mem_if.req_valid, 0);
        chk("rst_m_rsp_ready", mem_if.rsp_ready, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        set_req(1'b0, 1'b1, 32'h600, 32'h6, 4'h0);
        set_req(1'b1, 1'b1, 32'h700, 32'h7, 4'h0);
        mem_if.req_ready = 1'b1;
        settle();
        chk("rst_first_conflict", mem_if.req_addr, 32'h700);
        advance();
        settle();
`ifdef MEM_PORT_ARBITER_DMEM_PRIO_EN
        chk("rst_second_conflict", mem_if.req_addr, 32'h700);
`else
        chk("rst_second_conflict", mem_if.req_addr, 32'h600);
`endif
        advance();
        idle_all();

        // Randomized traffic against the model.
        i_pend = 1'b0; d_pend = 1'b0; rsp_hold = 1'b0; rsp_val = '0;
        i_cur = '0; d_cur = '0;
        for (int n = 0; n < 400; n++) begin
            if (!i_pend && $urandom_range(0, 99) < 50) begin
                i_pend = 1'b1;
                i_cur  = '{addr: $urandom, wdata: $urandom, byte_en: 4'($urandom_range(0, 15))};
            end
            if (!d_pend && $urandom_range(0, 99) < 50) begin
                d_pend = 1'b1;
                d_cur  = '{addr: $urandom, wdata: $urandom, byte_en: 4'($urandom_range(0, 15))};
            end
            set_req(1'b0, i_pend, i_cur.addr, i_cur.wdata, i_cur.byte_en);
            set_req(1'b1, d_pend, d_cur.addr, d_cur.wdata, d_cur.byte_en);
            if (!rsp_hold && q.size() > 0 && $urandom_range(0, 99) < 50) begin
                rsp_hold = 1'b1;
                rsp_val  = $urandom;
            end
            mem_if.rsp_valid  = rsp_hold;
            mem_if.rsp_data   = rsp_val;
            mem_if.req_ready  = ($urandom_range(0, 99) < 70);
            imem_if.rsp_ready = ($urandom_range(0, 99) < 70);
            dmem_if.rsp_ready = ($urandom_range(0, 99) < 70);
            settle();
            advance();
            if (fired_i)   i_pend   = 1'b0;
            if (fired_d)   d_pend   = 1'b0;
            if (fired_rsp) rsp_hold = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
